trg_link_framer_tmr: RTL and testbench

- Parametrised successor to the single-pair TMR trigger MGT data path.
- Frames 56-bit GEM cluster payloads for NUM_LINKS trigger links into 4-word, 16-bit/cycle frames at 160 MHz, one frame per BX.
- Adds a link state machine (IDLE/SYNC/RUN) and sticky TTC-flag capture.
- Optionally triplicates the framer core and majority-votes all outputs, counting voter disagreements.
- Sits between cluster packer output and the MGT TX user interface.

---
 rtl/trg_link_pkg.sv | 37 +++
 rtl/trg_link_framer_tmr_if.sv | 25 ++
 rtl/trg_link_framer_core.sv | 150 +++++++++++++++
 rtl/trg_link_framer_tmr.sv | 96 +++++++++
 tb/tb_trg_link_framer_tmr.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/trg_link_pkg.sv
// Shared constants, encodings and header selection for the GEM trigger link framer.
package trg_link_pkg;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  K28_0     = 8'h1C;
    localparam logic [7:0]  K23_7     = 8'hF7;
    localparam logic [7:0]  K28_7     = 8'hFC;
    localparam logic [15:0] IDLE_WORD = 16'hBC50;
    localparam logic [1:0]  HDR_ISK   = 2'b10;
    localparam logic [1:0]  DATA_ISK  = 2'b00;

    localparam int FRAME_WORDS = 4;
    localparam int PAYLOAD_W   = 56;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_SYNC = 2'd1,
        LS_RUN  = 2'd2
    } link_state_e;

    // Resync outranks BC0, which outranks the per-link overflow marker.
    function automatic logic [7:0] frame_header(input logic resync, input logic bc0,
                                                input logic ovf, input logic ttc_en);
        logic [7:0] hdr;
        if (ttc_en && resync) begin
            hdr = K28_0;
        end else if (ttc_en && bc0) begin
            hdr = K23_7;
        end else if (ovf) begin
            hdr = K28_7;
        end else begin
            hdr = K28_5;
        end
        return hdr;
    endfunction

endpackage

// File: rtl/trg_link_framer_tmr_if.sv
// Cluster-payload input and MGT TX word bundle between the packer and the framer.
interface trg_link_framer_tmr_if #(
    parameter int NUM_LINKS = 2
);
    import trg_link_pkg::*;

    logic [NUM_LINKS*PAYLOAD_W-1:0] gem_data;
    logic [NUM_LINKS-1:0]           overflow_i;
    logic                           bc0_i;
    logic                           resync_i;
    logic                           ready;
    logic [NUM_LINKS*16-1:0]        trg_tx_data;
    logic [NUM_LINKS*2-1:0]         trg_tx_isk;

    modport master (
        output gem_data, overflow_i, bc0_i, resync_i, ready,
        input  trg_tx_data, trg_tx_isk
    );

    modport slave (
        input  gem_data, overflow_i, bc0_i, resync_i, ready,
        output trg_tx_data, trg_tx_isk
    );

endinterface

// File: rtl/trg_link_framer_core.sv
// One framer copy: phase counter, link FSM, sticky TTC flags and per-link 4-word framing.
module trg_link_framer_core
    import trg_link_pkg::*;
#(
    parameter int NUM_LINKS       = 2,
    parameter int ALLOW_TTC_CHARS = 1,
    parameter int SYNC_FRAMES     = 16
) (
    input  logic                           clk_160,
    input  logic                           reset,
    input  logic [NUM_LINKS*PAYLOAD_W-1:0] gem_data,
    input  logic [NUM_LINKS-1:0]           overflow_i,
    input  logic                           bc0_i,
    input  logic                           resync_i,
    input  logic                           ready,
    output logic [NUM_LINKS*16-1:0]        tx_data,
    output logic [NUM_LINKS*2-1:0]         tx_isk,
    output logic [1:0]                     link_state,
    output logic [1:0]                     frame_phase
);

    localparam int         HI_W       = PAYLOAD_W - 8;
    localparam logic [1:0] LAST_PHASE = 2'(FRAME_WORDS - 1);
    localparam logic [7:0] LAST_SYNC  = 8'(SYNC_FRAMES - 1);
    localparam logic       TTC_EN     = (ALLOW_TTC_CHARS != 0);

    link_state_e                 state_q, state_d;
    logic [1:0]                  phase_q, phase_d;
    logic [7:0]                  sync_cnt_q, sync_cnt_d;
    logic                        bc0_flag_q, bc0_flag_d;
    logic                        resync_flag_q, resync_flag_d;
    logic [NUM_LINKS*HI_W-1:0]   payload_q, payload_d;
    logic [NUM_LINKS*16-1:0]     tx_data_q, tx_data_d;
    logic [NUM_LINKS*2-1:0]      tx_isk_q, tx_isk_d;
    logic                        frame_end_s, bc0_now_s, resync_now_s;

    // Phase, link FSM, sticky flags and payload capture at the last word of each frame.
    always_comb begin
        frame_end_s   = (phase_q == LAST_PHASE);
        bc0_now_s     = bc0_flag_q | bc0_i;
        resync_now_s  = resync_flag_q | resync_i;
        phase_d       = phase_q + 2'd1;
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        bc0_flag_d    = bc0_now_s;
        resync_flag_d = resync_now_s;
        payload_d     = payload_q;

        if (!ready) begin
            state_d    = LS_IDLE;
            sync_cnt_d = 8'd0;
        end else begin
            case (state_q)
                LS_IDLE: begin
                    if (frame_end_s) state_d = LS_SYNC;
                    else             state_d = LS_IDLE;
                end
                LS_SYNC: begin
                    if (frame_end_s && (sync_cnt_q == LAST_SYNC)) begin
                        state_d    = LS_RUN;
                        sync_cnt_d = 8'd0;
                    end else if (frame_end_s) begin
                        sync_cnt_d = sync_cnt_q + 8'd1;
                    end else begin
                        sync_cnt_d = sync_cnt_q;
                    end
                end
                LS_RUN:  state_d = LS_RUN;
                default: state_d = LS_IDLE;
            endcase
        end

        // Flags seen up to and including the sample cycle belong to the frame being sampled.
        if (frame_end_s) begin
            bc0_flag_d    = 1'b0;
            resync_flag_d = 1'b0;
            for (int k = 0; k < NUM_LINKS; k++) begin
                payload_d[k*HI_W +: HI_W] = gem_data[k*PAYLOAD_W+8 +: HI_W];
            end
        end else begin
            payload_d = payload_q;
        end
    end

    // Next TX word per link; word0 is built straight from the inputs being sampled.
    always_comb begin
        tx_data_d = {NUM_LINKS{IDLE_WORD}};
        tx_isk_d  = {NUM_LINKS{HDR_ISK}};
        for (int k = 0; k < NUM_LINKS; k++) begin
            if (state_d != LS_RUN) begin
                tx_data_d[k*16 +: 16] = IDLE_WORD;
                tx_isk_d[k*2 +: 2]    = HDR_ISK;
            end else begin
                case (phase_d)
                    2'd0: begin
                        tx_data_d[k*16 +: 16] = {frame_header(resync_now_s, bc0_now_s,
                                                              overflow_i[k], TTC_EN),
                                                 gem_data[k*PAYLOAD_W +: 8]};
                        tx_isk_d[k*2 +: 2]    = HDR_ISK;
                    end
                    2'd1: begin
                        tx_data_d[k*16 +: 16] = payload_q[k*HI_W +: 16];
                        tx_isk_d[k*2 +: 2]    = DATA_ISK;
                    end
                    2'd2: begin
                        tx_data_d[k*16 +: 16] = payload_q[k*HI_W+16 +: 16];
                        tx_isk_d[k*2 +: 2]    = DATA_ISK;
                    end
                    2'd3: begin
                        tx_data_d[k*16 +: 16] = payload_q[k*HI_W+32 +: 16];
                        tx_isk_d[k*2 +: 2]    = DATA_ISK;
                    end
                    default: begin
                        tx_data_d[k*16 +: 16] = IDLE_WORD;
                        tx_isk_d[k*2 +: 2]    = HDR_ISK;
                    end
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            phase_q       <= 2'd0;
            state_q       <= LS_IDLE;
            sync_cnt_q    <= 8'd0;
            bc0_flag_q    <= 1'b0;
            resync_flag_q <= 1'b0;
            payload_q     <= {(NUM_LINKS*HI_W){1'b0}};
            tx_data_q     <= {NUM_LINKS{IDLE_WORD}};
            tx_isk_q      <= {NUM_LINKS{HDR_ISK}};
        end else begin
            phase_q       <= phase_d;
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            bc0_flag_q    <= bc0_flag_d;
            resync_flag_q <= resync_flag_d;
            payload_q     <= payload_d;
            tx_data_q     <= tx_data_d;
            tx_isk_q      <= tx_isk_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_isk      = tx_isk_q;
    assign link_state  = state_q;
    assign frame_phase = phase_q;

endmodule

// File: rtl/trg_link_framer_tmr.sv
// Trigger link framer top: one or three framer cores, bitwise majority voter, disagreement counter.
module trg_link_framer_tmr
    import trg_link_pkg::*;
#(
    parameter int NUM_LINKS       = 2,
    parameter int TMR_EN          = 1,
    parameter int ALLOW_TTC_CHARS = 1,
    parameter int SYNC_FRAMES     = 16
) (
    input  logic                  clk_160,
    input  logic                  reset,
    trg_link_framer_tmr_if.slave  link_bus,
    output logic [1:0]            link_state,
    output logic [1:0]            frame_phase,
    output logic [15:0]           tmr_err_cnt
);

    localparam int DW     = NUM_LINKS * 16;
    localparam int KW     = NUM_LINKS * 2;
    localparam int VW     = DW + KW + 4;
    localparam int NCOPY  = (TMR_EN != 0) ? 3 : 1;

    logic [VW-1:0] copy_bus_s [NCOPY];
    logic [VW-1:0] voted_s;
    logic          disagree_s;
    logic [15:0]   tmr_err_cnt_q, tmr_err_cnt_d;

    for (genvar i = 0; i < NCOPY; i++) begin : g_copy
        logic [DW-1:0] copy_tx_data_s;
        logic [KW-1:0] copy_tx_isk_s;
        logic [1:0]    copy_state_s;
        logic [1:0]    copy_phase_s;

        trg_link_framer_core #(
            .NUM_LINKS       (NUM_LINKS),
            .ALLOW_TTC_CHARS (ALLOW_TTC_CHARS),
            .SYNC_FRAMES     (SYNC_FRAMES)
        ) u_core (
            .clk_160     (clk_160),
            .reset       (reset),
            .gem_data    (link_bus.gem_data),
            .overflow_i  (link_bus.overflow_i),
            .bc0_i       (link_bus.bc0_i),
            .resync_i    (link_bus.resync_i),
            .ready       (link_bus.ready),
            .tx_data     (copy_tx_data_s),
            .tx_isk      (copy_tx_isk_s),
            .link_state  (copy_state_s),
            .frame_phase (copy_phase_s)
        );

        assign copy_bus_s[i] = {copy_tx_data_s, copy_tx_isk_s, copy_state_s, copy_phase_s};
    end

    if (TMR_EN != 0) begin : g_vote
        // Bitwise 2-of-3 vote; any bit where the copies differ flags a disagreement.
        always_comb begin
            voted_s    = (copy_bus_s[0] & copy_bus_s[1]) |
                         (copy_bus_s[0] & copy_bus_s[2]) |
                         (copy_bus_s[1] & copy_bus_s[2]);
            disagree_s = |((copy_bus_s[0] ^ copy_bus_s[1]) | (copy_bus_s[0] ^ copy_bus_s[2]));
        end
    end else begin : g_single
        // Single copy passes straight through and can never disagree.
        always_comb begin
            voted_s    = copy_bus_s[0];
            disagree_s = 1'b0;
        end
    end

    // Saturating disagreement counter.
    always_comb begin
        tmr_err_cnt_d = tmr_err_cnt_q;
        if (disagree_s && (tmr_err_cnt_q != 16'hFFFF)) begin
            tmr_err_cnt_d = tmr_err_cnt_q + 16'd1;
        end else begin
            tmr_err_cnt_d = tmr_err_cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            tmr_err_cnt_q <= 16'd0;
        end else begin
            tmr_err_cnt_q <= tmr_err_cnt_d;
        end
    end

    assign link_bus.trg_tx_data = voted_s[VW-1 -: DW];
    assign link_bus.trg_tx_isk  = voted_s[KW+3 -: KW];
    assign link_state           = voted_s[3:2];
    assign frame_phase          = voted_s[1:0];
    assign tmr_err_cnt          = tmr_err_cnt_q;

endmodule

// File: tb/tb_trg_link_framer_tmr.sv
// Scoreboard bench: a TMR/TTC-enabled framer and a single-core/TTC-disabled framer share stimulus.
module tb_trg_link_framer_tmr;

    localparam int NL = 2;

    logic            clk_160 = 1'b0;
    logic            reset;
    logic [NL*56-1:0] gem_data;
    logic [NL-1:0]   overflow;
    logic            bc0, resync, ready;
    logic [1:0]      ls_a, ph_a, ls_b, ph_b;
    logic [15:0]     err_a, err_b;

    trg_link_framer_tmr_if #(.NUM_LINKS(NL)) if_a ();
    trg_link_framer_tmr_if #(.NUM_LINKS(NL)) if_b ();

    assign if_a.gem_data   = gem_data;
    assign if_a.overflow_i = overflow;
    assign if_a.bc0_i      = bc0;
    assign if_a.resync_i   = resync;
    assign if_a.ready      = ready;
    assign if_b.gem_data   = gem_data;
    assign if_b.overflow_i = overflow;
    assign if_b.bc0_i      = bc0;
    assign if_b.resync_i   = resync;
    assign if_b.ready      = ready;

    trg_link_framer_tmr #(.NUM_LINKS(NL), .TMR_EN(1), .ALLOW_TTC_CHARS(1), .SYNC_FRAMES(16)) dut (
        .clk_160(clk_160), .reset(reset), .link_bus(if_a.slave),
        .link_state(ls_a), .frame_phase(ph_a), .tmr_err_cnt(err_a));

    trg_link_framer_tmr #(.NUM_LINKS(NL), .TMR_EN(0), .ALLOW_TTC_CHARS(0), .SYNC_FRAMES(16)) dut_b (
        .clk_160(clk_160), .reset(reset), .link_bus(if_b.slave),
        .link_state(ls_b), .frame_phase(ph_b), .tmr_err_cnt(err_b));

    always #3 clk_160 = ~clk_160;

    typedef struct {
        string       tag;
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic [3:0]  isk;
        logic [1:0]  ls;
        logic [1:0]  ph;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   push_ph = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] da, input logic [31:0] db,
                        input logic [3:0] isk, input logic [1:0] ls);
        exp_t e;
        e.tag = tag; e.data_a = da; e.data_b = db; e.isk = isk; e.ls = ls;
        e.ph  = 2'(push_ph % 4);
        push_ph++;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input string tag, input logic [1:0] ls);
        push(tag, 32'hBC50BC50, 32'hBC50BC50, 4'b1010, ls);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, "/data_a"}, if_a.trg_tx_data, e.data_a);
            check_val({e.tag, "/isk_a"},  32'(if_a.trg_tx_isk), 32'(e.isk));
            check_val({e.tag, "/ls_a"},   32'(ls_a), 32'(e.ls));
            check_val({e.tag, "/ph_a"},   32'(ph_a), 32'(e.ph));
            check_val({e.tag, "/data_b"}, if_b.trg_tx_data, e.data_b);
            check_val({e.tag, "/isk_b"},  32'(if_b.trg_tx_isk), 32'(e.isk));
            check_val({e.tag, "/ls_b"},   32'(ls_b), 32'(e.ls));
            check_val({e.tag, "/ph_b"},   32'(ph_b), 32'(e.ph));
        end
    endtask

    task automatic tick();
        @(posedge clk_160);
        @(negedge clk_160);
        pop_check();
    endtask

    task automatic idle_run(input string tag, input logic [1:0] ls, input int n);
        for (int i = 0; i < n; i++) begin
            push_idle(tag, ls);
            tick();
        end
    endtask

    // Expected words of a RUN frame; ttc_hdr != 0 overrides the header on the TTC-enabled DUT.
    task automatic push_words(input string tag, input logic [55:0] d0, input logic [55:0] d1,
                              input logic [1:0] ovf, input logic [7:0] ttc_hdr, input int nwords);
        logic [7:0]  hb0, hb1, ha0, ha1;
        logic [31:0] wa, wb;
        hb0 = ovf[0] ? 8'hFC : 8'hBC;
        hb1 = ovf[1] ? 8'hFC : 8'hBC;
        ha0 = (ttc_hdr != 8'h00) ? ttc_hdr : hb0;
        ha1 = (ttc_hdr != 8'h00) ? ttc_hdr : hb1;
        for (int w = 0; w < nwords; w++) begin
            case (w)
                0: begin wa = {ha1, d1[7:0], ha0, d0[7:0]}; wb = {hb1, d1[7:0], hb0, d0[7:0]}; end
                1: begin wa = {d1[23:8],  d0[23:8]};  wb = wa; end
                2: begin wa = {d1[39:24], d0[39:24]}; wb = wa; end
                3: begin wa = {d1[55:40], d0[55:40]}; wb = wa; end
                default: begin wa = 32'h0; wb = 32'h0; end
            endcase
            push($sformatf("%s/w%0d", tag, w), wa, wb, (w == 0) ? 4'b1010 : 4'b0000, 2'd2);
        end
    endtask

    // Called while the current cycle is phase 3; optionally pulses TTC inputs on one phase.
    task automatic send_frame(input string tag, input logic [55:0] d0, input logic [55:0] d1,
                              input logic [1:0] ovf, input logic [7:0] ttc_hdr,
                              input int pulse_ph, input logic p_bc0, input logic p_rs);
        gem_data = {d1, d0};
        overflow = ovf;
        push_words(tag, d0, d1, ovf, ttc_hdr, 4);
        for (int c = 0; c < 4; c++) begin
            bc0    = ((c == 0 ? 3 : c - 1) == pulse_ph) && p_bc0;
            resync = ((c == 0 ? 3 : c - 1) == pulse_ph) && p_rs;
            tick();
        end
        bc0    = 1'b0;
        resync = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time %0t reached, limit 100000", $time);
        $fatal(1);
    end

    initial begin : stim
        logic [55:0] r0, r1;
        reset = 1'b1; ready = 1'b0; bc0 = 1'b0; resync = 1'b0;
        gem_data = '0; overflow = '0;
        repeat (3) @(posedge clk_160);
        @(negedge clk_160);
        push_idle("reset", 2'd0);
        pop_check();
        check_val("reset/err_a", 32'(err_a), 32'd0);
        check_val("reset/err_b", 32'(err_b), 32'd0);
        reset = 1'b0;

        idle_run("idle", 2'd0, 20);

        ready = 1'b1;
        idle_run("pre_sync", 2'd0, 3);
        idle_run("sync", 2'd1, 64);

        send_frame("f1", 56'h123456789ABCDE, 56'h0, 2'b10, 8'h00, 1, 1'b1, 1'b1);
        send_frame("f2", 56'hA5A5A5A5A5A5A5, 56'h0F0E0D0C0B0A09, 2'b11, 8'h1C, -1, 1'b0, 1'b0);
        send_frame("f3", 56'h00000000000001, 56'hFFFFFFFFFFFFFF, 2'b00, 8'h00, 0, 1'b1, 1'b0);
        send_frame("f4", 56'h0123456789ABCD, 56'h89ABCDEF012345, 2'b01, 8'hF7, -1, 1'b0, 1'b0);
        send_frame("f5", 56'h11223344556677, 56'h8899AABBCCDDEE, 2'b00, 8'h1C, 3, 1'b0, 1'b1);
        r0 = {24'($urandom), $urandom};
        r1 = {24'($urandom), $urandom};
        send_frame("f6", r0, r1, 2'b00, 8'h00, -1, 1'b0, 1'b0);

        gem_data = {56'h22222222222222, 56'h11111111111111};
        overflow = 2'b00;
        push_words("drop", 56'h11111111111111, 56'h22222222222222, 2'b00, 8'h00, 3);
        repeat (3) tick();
        ready = 1'b0;
        idle_run("drop_idle", 2'd0, 1);
        ready = 1'b1;
        idle_run("resync_seq", 2'd1, 64);
        send_frame("f7", 56'hCAFEF00DBEEF42, 56'h5A5A5A5A5A5A5A, 2'b10, 8'h00, -1, 1'b0, 1'b0);

        ready = 1'b0;
        idle_run("stop", 2'd0, 1);
        force dut.g_copy[1].copy_tx_data_s = 32'h3C503C50;
        idle_run("tmr_force", 2'd0, 5);
        release dut.g_copy[1].copy_tx_data_s;
        check_val("tmr/cnt5", 32'(err_a), 32'd5);
        idle_run("tmr_after", 2'd0, 1);
        check_val("tmr/cnt5_hold", 32'(err_a), 32'd5);

        force dut.tmr_err_cnt_q = 16'hFFFE;
        #1;
        release dut.tmr_err_cnt_q;
        check_val("tmr/preload", 32'(err_a), 32'h0000FFFE);
        force dut.g_copy[1].copy_tx_data_s = 32'h3C503C50;
        idle_run("tmr_sat", 2'd0, 3);
        release dut.g_copy[1].copy_tx_data_s;
        check_val("tmr/sat", 32'(err_a), 32'h0000FFFF);
        idle_run("tmr_sat_hold", 2'd0, 1);
        check_val("tmr/sat_hold", 32'(err_a), 32'h0000FFFF);
        check_val("single/err_b", 32'(err_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
